// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, flag layout and the lookahead carry helper
package adder_pkg;

  localparam int GROUP_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Flat sum-of-products carry into position n: OR_j(g[j] & p[j+1..n-1]) | (cin & p[0..n-1]).
  // Supports up to 32 propagate/generate inputs.
  function automatic logic la_carry(input logic [31:0] p, input logic [31:0] g,
                                    input logic cin, input int n);
    logic carry;
    logic term;
    carry = 1'b0;
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int m = j + 1; m < n; m++) term = term & p[m];
      carry = carry | term;
    end
    term = cin;
    for (int m = 0; m < n; m++) term = term & p[m];
    return carry | term;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - operation/result handshake bundle of the adder/subtractor
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             use_cin;
  logic             sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, cin, use_cin, sub, tag_in, out_ready,
    input  in_ready, out_valid, result, flags, tag_out
  );

  modport slave (
    input  in_valid, a, b, cin, use_cin, sub, tag_in, out_ready,
    output in_ready, out_valid, result, flags, tag_out
  );
endinterface

// File: rtl/pipelined_cla_addsub_cla_group.sv
// rtl/pipelined_cla_addsub_cla_group.sv - GROUP_W-bit carry-lookahead group with group P/G
module cla_group
  import adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               cin_i,
  output logic [GROUP_W-1:0] sum_o,
  output logic               p_o,
  output logic               g_o,
  output logic               cout_o
);
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    c = '0;
    for (int i = 0; i < GROUP_W; i++) c[i] = la_carry(32'(p), 32'(g), cin_i, i);
  end

  assign sum_o  = p ^ c;
  assign p_o    = &p;
  assign g_o    = la_carry(32'(p), 32'(g), 1'b0, GROUP_W);
  assign cout_o = g_o | (p_o & cin_i);
endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - STAGES-deep pipelined CLA add/sub with NZCV flags
// Optional flags datapath selected by ADDSUB_FLAGS_EN; otherwise flags read as zero.
module pipelined_cla_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic                    clk,
  input logic                    reset,
  pipelined_cla_addsub_if.slave  bus
);
  localparam int SW   = WIDTH / STAGES;
  localparam int NG   = SW / GROUP_W;
  localparam int LAST = STAGES - 1;

  logic              adv;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              c_d [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];

  assign adv = !valid_q[LAST] || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_out;
    logic             c_in;
    logic [TAG_W-1:0] t_in;
    logic [SW-1:0]    sa, sb, ssum;
    logic [NG-1:0]    gp, gg, gco;
    logic [NG:0]      gc;
    logic             unused_gco;

    if (k == 0) begin : g_first
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.use_cin ? bus.cin : bus.sub;
      assign s_in = '0;
      assign t_in = bus.tag_in;
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign c_in = c_q[k-1];
      assign s_in = s_q[k-1];
      assign t_in = tag_q[k-1];
    end

    assign sa = a_in[k*SW +: SW];
    assign sb = b_in[k*SW +: SW];

    // Second-level lookahead: every group carry is a flat function of the slice carry-in.
    always_comb begin
      gc = '0;
      for (int i = 0; i <= NG; i++) gc[i] = la_carry(32'(gp), 32'(gg), c_in, i);
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group u_grp (
        .a_i    (sa[j*GROUP_W +: GROUP_W]),
        .b_i    (sb[j*GROUP_W +: GROUP_W]),
        .cin_i  (gc[j]),
        .sum_o  (ssum[j*GROUP_W +: GROUP_W]),
        .p_o    (gp[j]),
        .g_o    (gg[j]),
        .cout_o (gco[j])
      );
    end
    assign unused_gco = &{1'b0, gco};

    always_comb begin
      s_out = s_in;
      s_out[k*SW +: SW] = ssum;
    end

    assign a_d[k]   = a_in;
    assign b_d[k]   = b_in;
    assign s_d[k]   = s_out;
    assign c_d[k]   = gc[NG];
    assign tag_d[k] = t_in;
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) valid_d[k] = valid_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else if (adv) valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

`ifdef ADDSUB_FLAGS_EN
  flags_t flags_d, flags_q;

  always_comb begin
    flags_d   = '0;
    flags_d.n = s_d[LAST][WIDTH-1];
    flags_d.z = (s_d[LAST] == '0);
    flags_d.c = c_d[LAST];
    flags_d.v = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else if (adv) flags_q <= flags_d;
  end

  assign bus.flags = valid_q[LAST] ? flags_q : 4'b0000;
`else
  assign bus.flags = 4'b0000;
`endif

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.result    = valid_q[LAST] ? s_q[LAST] : '0;
  assign bus.tag_out   = valid_q[LAST] ? tag_q[LAST] : '0;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - randomized scoreboard bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
  import adder_pkg::*;

  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
`ifdef ADDSUB_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_cla_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  pipelined_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   lat_chk = 1'b0;
  int   ready_mode = 0;
  int   hold_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain wide arithmetic for C, signed-range test for V.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic uc, input logic sub,
                                 input logic [TAG_W-1:0] tag);
    exp_t                    e;
    logic [WIDTH-1:0]        be;
    logic                    c0;
    logic [WIDTH:0]          u;
    logic signed [WIDTH:0]   s;
    logic [3:0]              fl;
    be = sub ? ~b : b;
    c0 = uc ? cin : sub;
    u  = {1'b0, a} + {1'b0, be} + (WIDTH+1)'(c0);
    s  = $signed({a[WIDTH-1], a}) + $signed({be[WIDTH-1], be}) + $signed({{WIDTH{1'b0}}, c0});
    fl = '0;
    fl[FLAG_N] = u[WIDTH-1];
    fl[FLAG_Z] = (u[WIDTH-1:0] == '0);
    fl[FLAG_C] = u[WIDTH];
    fl[FLAG_V] = (s[WIDTH] != s[WIDTH-1]);
    e.res = u[WIDTH-1:0];
    e.fl  = FLAGS_EN ? fl : 4'b0000;
    e.tag = tag;
    e.cyc = cyc;
    return e;
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic uc, input logic sub,
                      input logic [TAG_W-1:0] tag, output bit acc);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.use_cin  = uc;
    bus.sub      = sub;
    bus.tag_in   = tag;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        bus.out_ready = (hold_cnt == 0);
        if (hold_cnt > 0 && bus.out_valid) hold_cnt--;
      end
    endcase
    #3;
    acc = v && bus.in_ready;
    if (acc) sb_q.push_back(model(a, b, cin, uc, sub, tag));
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic uc, input logic sub,
                       input logic [TAG_W-1:0] tag);
    bit acc;
    int tries;
    tries = 0;
    do begin
      step(1'b1, a, b, cin, uc, sub, tag, acc);
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got in_ready low for %0d cycles want acceptance", tries);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, acc);
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(WIDTH-1){1'b0}}};
      3:       v = {1'b0, {(WIDTH-1){1'b1}}};
      4:       v = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic issue_rand();
    issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), TAG_W'($urandom));
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each output transfer.
  bit               hold_prev = 1'b0;
  logic [WIDTH-1:0] h_res;
  logic [3:0]       h_fl;
  logic [TAG_W-1:0] h_tag;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold_prev = 1'b0;
      end else begin
        check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (hold_prev) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_result", bus.result, h_res);
          check("hold_flags", bus.flags, h_fl);
          check("hold_tag", bus.tag_out, h_tag);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got result %h want no output", bus.result);
          end else begin
            e = sb_q.pop_front();
            check("result", bus.result, e.res);
            check("flags", bus.flags, e.fl);
            check("tag", bus.tag_out, e.tag);
            if (lat_chk) check("latency", cyc - e.cyc, STAGES);
          end
        end else if (!bus.out_valid) begin
          check("idle_result", bus.result, 0);
          check("idle_flags", bus.flags, 0);
          check("idle_tag", bus.tag_out, 0);
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        h_res = bus.result;
        h_fl  = bus.flags;
        h_tag = bus.tag_out;
      end
    end
  end

  initial begin
    int w;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = '1;
    bus.b         = '1;
    bus.cin       = 1'b0;
    bus.use_cin   = 1'b0;
    bus.sub       = 1'b0;
    bus.tag_in    = '1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #3;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_tag", bus.tag_out, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed corners at full rate with latency checking.
    ready_mode = 0;
    lat_chk = 1'b1;
    issue('1, 64'd1, 1'b0, 1'b0, 1'b0, 5'd3);
    idle(3);
    issue(64'd5, 64'd7, 1'b0, 1'b0, 1'b1, 5'd9);
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0, 1'b1, 5'd17);
    issue(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 1'b0, 5'd21);
    issue(64'd0, 64'd1, 1'b0, 1'b1, 1'b1, 5'd30);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 5'd31);
    issue('0, '0, 1'b0, 1'b0, 1'b1, 5'd1);
    idle(3);
    repeat (8) issue_rand();
    idle(3);
    lat_chk = 1'b0;

    // Consumer stalls for three output-valid cycles mid-stream.
    ready_mode = 2;
    issue_rand();
    issue_rand();
    hold_cnt = 3;
    repeat (6) issue_rand();
    idle(4);

    // Random traffic with bubbles and random back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue_rand();
    end

    // Reset with two operations in flight: nothing may come out afterwards.
    ready_mode = 0;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      idle(1);
      w++;
    end
    issue_rand();
    issue_rand();
    mon_en = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    #3;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_flags", bus.flags, 0);
    check("midrst_tag", bus.tag_out, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(4);

    ready_mode = 1;
    repeat (50) issue_rand();

    ready_mode = 0;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      idle(1);
      w++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding want 0", sb_q.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
